// File: rtl/sd_block_buffer.sv
// sd_block_buffer: single-block (512 byte) staging buffer and READ/WRITE
// sequencer sitting directly above sd_card_controller.
// Optional feature macro: SD_BUF_TIMEOUT_EN enables a cycle watchdog that
// aborts a stalled transaction through the ERR state and pulses `error`.
module sd_block_buffer #(
    parameter int RD_SKIP        = 1,
    parameter int WR_SKIP        = 6,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] lba,
    output logic        ready,
    output logic        done,
    output logic        error,
    input  logic [8:0]  buf_addr,
    input  logic [7:0]  buf_wdata,
    input  logic        buf_we,
    output logic [7:0]  buf_rdata,
    output logic        sd_op_code,
    output logic        sd_execute,
    output logic [31:0] sd_block_address,
    output logic [7:0]  sd_outgoing_byte,
    input  logic [7:0]  sd_incoming_byte,
    input  logic        sd_finished_byte,
    input  logic        sd_finished_block,
    input  logic        sd_busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_XFER  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    // Byte-counter window bounds for the data phase of each direction
    localparam logic [9:0]  RD_SKIP_C = 10'(RD_SKIP);
    localparam logic [9:0]  WR_SKIP_C = 10'(WR_SKIP);
    localparam logic [10:0] RD_LO     = 11'(RD_SKIP);
    localparam logic [10:0] RD_HI     = 11'(RD_SKIP) + 11'd512;
    localparam logic [10:0] WR_LO     = 11'(WR_SKIP);
    localparam logic [10:0] WR_HI     = 11'(WR_SKIP) + 11'd512;

    logic [2:0]  r_state;
    logic        r_op;
    logic [31:0] r_lba;
    logic [9:0]  r_byteCnt;
    logic        r_done;
    logic        r_exec;
    logic [7:0]  r_outByte;
    logic [7:0]  r_rdata;
    logic [7:0]  r_mem [0:511];

    logic        w_ready;
    logic [9:0]  w_cntNext;
    logic [8:0]  w_rdIdx;
    logic        w_rdHit;
    logic [8:0]  w_wrIdx;
    logic        w_wrHit;
    logic        w_ctrlWe;
    logic        w_hostWe;
    logic        w_timeout;

    // Host may only touch the RAM while the sequencer is idle and the controller is free
    assign w_ready   = (r_state == S_IDLE) && !sd_busy;

    // Byte counter saturates rather than wrapping so trailing bytes never alias data slots
    assign w_cntNext = (r_byteCnt == 10'd1023) ? r_byteCnt : r_byteCnt + 10'd1;

    // Read side: the byte being reported now lands at byte_cnt - RD_SKIP
    assign w_rdIdx   = 9'(r_byteCnt - RD_SKIP_C);
    assign w_rdHit   = ({1'b0, r_byteCnt} >= RD_LO) && ({1'b0, r_byteCnt} < RD_HI);

    // Write side: after this pulse the controller wants the byte at (byte_cnt+1) - WR_SKIP
    assign w_wrIdx   = 9'(w_cntNext - WR_SKIP_C);
    assign w_wrHit   = ({1'b0, w_cntNext} >= WR_LO) && ({1'b0, w_cntNext} < WR_HI);

    assign w_ctrlWe  = (r_state == S_XFER) && !r_op && sd_finished_byte && w_rdHit;
    assign w_hostWe  = buf_we && w_ready;

`ifdef SD_BUF_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    logic [31:0] r_wdog;
    logic        r_error;

    // Watchdog counts stalled cycles while a transaction is in flight, cleared by byte progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= 32'd0;
        end else if (((r_state == S_ISSUE) || (r_state == S_XFER)) && !sd_finished_byte) begin
            r_wdog <= r_wdog + 32'd1;
        end else begin
            r_wdog <= 32'd0;
        end
    end

    assign w_timeout = ((r_state == S_ISSUE) || (r_state == S_XFER)) && (r_wdog == TIMEOUT_LAST)
                       && !sd_finished_byte && !sd_finished_block;
    assign error     = r_error;
`else
    assign w_timeout = 1'b0;
    assign error     = 1'b0;
`endif

    // Sector RAM write port: controller data wins; host writes only get through while ready
    always_ff @(posedge clk) begin
        if (w_ctrlWe) begin
            r_mem[w_rdIdx] <= sd_incoming_byte;
        end else if (w_hostWe) begin
            r_mem[buf_addr] <= buf_wdata;
        end
    end

    // Host read data is registered every cycle so it reflects current contents in any state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 8'h00;
        end else begin
            r_rdata <= r_mem[buf_addr];
        end
    end

    // Transaction sequencer: idle -> issue -> transfer -> done (or watchdog abort)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_op      <= 1'b0;
            r_lba     <= 32'd0;
            r_byteCnt <= 10'd0;
            r_done    <= 1'b0;
            r_exec    <= 1'b0;
            r_outByte <= 8'hFF;
`ifdef SD_BUF_TIMEOUT_EN
            r_error   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef SD_BUF_TIMEOUT_EN
            r_error <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (start && w_ready) begin
                        r_op      <= op;
                        r_lba     <= lba;
                        r_byteCnt <= 10'd0;
                        r_outByte <= 8'hFF;
                        r_exec    <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (sd_busy) begin
                        r_exec  <= 1'b0;
                        r_state <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (sd_finished_byte) begin
                        r_byteCnt <= w_cntNext;
                        if (r_op) begin
                            r_outByte <= w_wrHit ? r_mem[w_wrIdx] : 8'hFF;
                        end
                    end
                    if (sd_finished_block) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                S_ERR: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            if (w_timeout) begin
                r_exec  <= 1'b0;
                r_state <= S_ERR;
`ifdef SD_BUF_TIMEOUT_EN
                r_error <= 1'b1;
`endif
            end
        end
    end

    assign ready            = w_ready;
    assign done             = r_done;
    assign buf_rdata        = r_rdata;
    assign sd_op_code       = r_op;
    assign sd_execute       = r_exec;
    assign sd_block_address = r_lba;
    assign sd_outgoing_byte = r_outByte;

endmodule

// File: tb/tb_sd_block_buffer.sv
// tb_sd_block_buffer: self-checking bench for sd_block_buffer with a simple
// controller model, a bench-side RAM model and an expected-value queue.
module tb_sd_block_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        op;
    logic [31:0] lba;
    logic [8:0]  buf_addr;
    logic [7:0]  buf_wdata;
    logic        buf_we;
    logic [7:0]  sd_incoming_byte;
    logic        sd_finished_byte;
    logic        sd_finished_block;
    logic        sd_busy;

    logic        ready;
    logic        done;
    logic        error;
    logic [7:0]  buf_rdata;
    logic        sd_op_code;
    logic        sd_execute;
    logic [31:0] sd_block_address;
    logic [7:0]  sd_outgoing_byte;

    int compared   = 0;
    int mismatched = 0;
    int doneCount  = 0;
    int errorCount = 0;

    logic [7:0] model [512];
    logic [7:0] expQ [$];

    typedef struct {
        logic       we;
        logic [8:0] addr;
        logic [7:0] wdata;
        logic       chk;
        logic [7:0] expRd;
    } hostVec_t;

    hostVec_t vecs [10];

    always #5 clk = ~clk;

    sd_block_buffer #(
        .RD_SKIP(1),
        .WR_SKIP(6),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .op(op),
        .lba(lba),
        .ready(ready),
        .done(done),
        .error(error),
        .buf_addr(buf_addr),
        .buf_wdata(buf_wdata),
        .buf_we(buf_we),
        .buf_rdata(buf_rdata),
        .sd_op_code(sd_op_code),
        .sd_execute(sd_execute),
        .sd_block_address(sd_block_address),
        .sd_outgoing_byte(sd_outgoing_byte),
        .sd_incoming_byte(sd_incoming_byte),
        .sd_finished_byte(sd_finished_byte),
        .sd_finished_block(sd_finished_block),
        .sd_busy(sd_busy)
    );

    // Count every cycle the completion and abort pulses are seen
    always @(negedge clk) begin
        if (done === 1'b1) doneCount++;
        if (error === 1'b1) errorCount++;
    end

    // Hard stop in case a sequence never completes
    initial begin
        #5_000_000;
        $display("[TB] FAIL global_timeout: got no end of test, wanted finish before 5ms");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    // Table-driven host port access, read data checked one cycle after the address
    task automatic applyStimulus();
        bit prevChk = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (prevChk) checkOutput("host_table_rdata", {24'd0, buf_rdata}, {24'd0, expQ.pop_front()});
            buf_addr  = vecs[i].addr;
            buf_wdata = vecs[i].wdata;
            buf_we    = vecs[i].we;
            if (vecs[i].we) model[vecs[i].addr] = vecs[i].wdata;
            if (vecs[i].chk) expQ.push_back(vecs[i].expRd);
            prevChk = vecs[i].chk;
        end
        @(negedge clk);
        buf_we = 1'b0;
        if (prevChk) checkOutput("host_table_rdata", {24'd0, buf_rdata}, {24'd0, expQ.pop_front()});
    endtask

    task automatic readAll(input string name);
        for (int i = 0; i <= 512; i++) begin
            @(negedge clk);
            if (expQ.size() > 0) checkOutput(name, {24'd0, buf_rdata}, {24'd0, expQ.pop_front()});
            if (i < 512) begin
                buf_addr = 9'(i);
                expQ.push_back(model[i]);
            end
        end
    endtask

    task automatic hostFillInverted();
        for (int i = 0; i < 512; i++) begin
            logic [7:0] v;
            v = 8'(i);
            v = ~v;
            @(negedge clk);
            buf_addr  = 9'(i);
            buf_wdata = v;
            buf_we    = 1'b1;
            model[i]  = v;
        end
        @(negedge clk);
        buf_we = 1'b0;
    endtask

    task automatic startXfer(input logic o, input logic [31:0] l);
        @(negedge clk);
        checkOutput("ready_before_start", {31'd0, ready}, 32'd1);
        start = 1'b1;
        op    = o;
        lba   = l;
        @(negedge clk);
        start = 1'b0;
        checkOutput("execute_after_start", {31'd0, sd_execute}, 32'd1);
        checkOutput("op_code", {31'd0, sd_op_code}, {31'd0, o});
        sd_busy = 1'b1;
        @(negedge clk);
        checkOutput("execute_dropped", {31'd0, sd_execute}, 32'd0);
        checkOutput("ready_in_xfer", {31'd0, ready}, 32'd0);
        checkOutput("block_address", sd_block_address, l);
    endtask

    task automatic sendPulse(input logic byteEn, input logic [7:0] b, input logic blk);
        @(negedge clk);
        sd_incoming_byte  = b;
        sd_finished_byte  = byteEn;
        sd_finished_block = blk;
        @(negedge clk);
        sd_finished_byte  = 1'b0;
        sd_finished_block = 1'b0;
    endtask

    task automatic writePulse(input int k);
        int idx;
        idx = k - 6;
        @(negedge clk);
        sd_finished_byte = 1'b1;
        expQ.push_back((idx >= 0 && idx < 512) ? model[idx] : 8'hFF);
        @(negedge clk);
        sd_finished_byte = 1'b0;
        checkOutput("outgoing_byte", {24'd0, sd_outgoing_byte}, {24'd0, expQ.pop_front()});
    endtask

    // Called on the negedge right after finished_block was sampled
    task automatic finishAfterBlock(input string name, input int doneBefore);
        sd_busy = 1'b0;
        checkOutput({name, "_done_high"}, {31'd0, done}, 32'd1);
        @(negedge clk);
        checkOutput({name, "_done_low"}, {31'd0, done}, 32'd0);
        checkOutput({name, "_ready_back"}, {31'd0, ready}, 32'd1);
        @(negedge clk);
        checkOutput({name, "_done_count"}, doneCount - doneBefore, 32'd1);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0; start = 1'b0; op = 1'b0; lba = 32'd0;
        buf_addr = 9'd0; buf_wdata = 8'd0; buf_we = 1'b0;
        sd_incoming_byte = 8'd0; sd_finished_byte = 1'b0; sd_finished_block = 1'b0; sd_busy = 1'b0;

        vecs[0] = '{1'b1, 9'h000, 8'h11, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 9'h1FF, 8'h22, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 9'h0AA, 8'h33, 1'b0, 8'h00};
        vecs[3] = '{1'b1, 9'h100, 8'h55, 1'b0, 8'h00};
        vecs[4] = '{1'b0, 9'h000, 8'h00, 1'b1, 8'h11};
        vecs[5] = '{1'b0, 9'h1FF, 8'h00, 1'b1, 8'h22};
        vecs[6] = '{1'b0, 9'h0AA, 8'h00, 1'b1, 8'h33};
        vecs[7] = '{1'b0, 9'h100, 8'h00, 1'b1, 8'h55};
        vecs[8] = '{1'b1, 9'h0AA, 8'h44, 1'b0, 8'h00};
        vecs[9] = '{1'b0, 9'h0AA, 8'h00, 1'b1, 8'h44};

        repeat (3) @(negedge clk);
        checkOutput("rst_ready", {31'd0, ready}, 32'd1);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_error", {31'd0, error}, 32'd0);
        checkOutput("rst_execute", {31'd0, sd_execute}, 32'd0);
        checkOutput("rst_op_code", {31'd0, sd_op_code}, 32'd0);
        checkOutput("rst_block_address", sd_block_address, 32'd0);
        checkOutput("rst_outgoing", {24'd0, sd_outgoing_byte}, 32'hFF);
        checkOutput("rst_rdata", {24'd0, buf_rdata}, 32'd0);
        rst_n = 1'b1;

        $display("[TB] start gating while controller busy");
        @(negedge clk);
        sd_busy = 1'b1; start = 1'b1; op = 1'b0; lba = 32'h99;
        @(negedge clk);
        checkOutput("gate_ready_low", {31'd0, ready}, 32'd0);
        checkOutput("gate_no_execute", {31'd0, sd_execute}, 32'd0);
        @(negedge clk);
        checkOutput("gate_no_execute2", {31'd0, sd_execute}, 32'd0);
        start = 1'b0; sd_busy = 1'b0;
        @(negedge clk);
        checkOutput("gate_no_execute3", {31'd0, sd_execute}, 32'd0);
        checkOutput("gate_ready_high", {31'd0, ready}, 32'd1);

        $display("[TB] host port table");
        applyStimulus();

        $display("[TB] read transaction");
        d0 = doneCount;
        startXfer(1'b0, 32'h10);
        sendPulse(1'b1, 8'hFE, 1'b0);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 256; i++) begin
                sendPulse(1'b1, 8'(i), 1'b0);
                model[r * 256 + i] = 8'(i);
            end
        end
        sendPulse(1'b1, 8'hAB, 1'b0);
        sendPulse(1'b1, 8'hCD, 1'b0);
        sendPulse(1'b0, 8'h00, 1'b1);
        finishAfterBlock("read", d0);
        checkOutput("read_block_address", sd_block_address, 32'h10);
        readAll("read_ram");

        $display("[TB] write transaction");
        hostFillInverted();
        d0 = doneCount;
        startXfer(1'b1, 32'h20);
        checkOutput("write_outgoing_idle", {24'd0, sd_outgoing_byte}, 32'hFF);
        @(negedge clk);
        buf_addr = 9'd5; buf_wdata = 8'h55; buf_we = 1'b1;
        @(negedge clk);
        buf_we = 1'b0;
        for (int k = 1; k <= 520; k++) writePulse(k);
        sendPulse(1'b0, 8'h00, 1'b1);
        finishAfterBlock("write", d0);
        readAll("ram_after_write");

        $display("[TB] coincident last byte and block end");
        d0 = doneCount;
        startXfer(1'b0, 32'h30);
        sendPulse(1'b1, 8'hFE, 1'b0);
        for (int i = 0; i < 512; i++) begin
            logic [7:0] b;
            b = 8'(i * 7 + 3);
            model[i] = b;
            sendPulse(1'b1, b, (i == 511));
        end
        finishAfterBlock("coincident", d0);
        readAll("coincident_ram");

        $display("[TB] reset in the middle of a write");
        startXfer(1'b1, 32'h40);
        for (int k = 1; k <= 8; k++) writePulse(k);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_execute", {31'd0, sd_execute}, 32'd0);
        checkOutput("mid_rst_op_code", {31'd0, sd_op_code}, 32'd0);
        checkOutput("mid_rst_block_address", sd_block_address, 32'd0);
        checkOutput("mid_rst_outgoing", {24'd0, sd_outgoing_byte}, 32'hFF);
        checkOutput("mid_rst_rdata", {24'd0, buf_rdata}, 32'd0);
        checkOutput("mid_rst_done", {31'd0, done}, 32'd0);
        checkOutput("mid_rst_ready_busy", {31'd0, ready}, 32'd0);
        sd_busy = 1'b0;
        #1;
        checkOutput("mid_rst_ready_idle", {31'd0, ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        readAll("ram_after_reset");

        $display("[TB] no controller response");
        @(negedge clk);
        start = 1'b1; op = 1'b0; lba = 32'h50;
        @(negedge clk);
        start = 1'b0;
        checkOutput("stall_execute", {31'd0, sd_execute}, 32'd1);
`ifdef SD_BUF_TIMEOUT_EN
        begin
            int waited = 0;
            while (error !== 1'b1 && waited < 300) begin
                @(negedge clk);
                waited++;
            end
            checkOutput("timeout_error_seen", {31'd0, error}, 32'd1);
            checkOutput("timeout_cycle_window", {31'd0, (waited >= 99 && waited <= 101)}, 32'd1);
            @(negedge clk);
            checkOutput("timeout_error_low", {31'd0, error}, 32'd0);
            checkOutput("timeout_ready_back", {31'd0, ready}, 32'd1);
            checkOutput("timeout_error_count", errorCount, 32'd1);
        end
`else
        repeat (150) @(negedge clk);
        checkOutput("stall_still_issue", {31'd0, sd_execute}, 32'd1);
        checkOutput("stall_not_ready", {31'd0, ready}, 32'd0);
        checkOutput("stall_error_never", errorCount, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("stall_cleared", {31'd0, sd_execute}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
